reg_cmd_master: RTL and testbench

- Initiator end of the byte-wide register bus used by the trace register blocks: it drives `reg_address`, `reg_bytecnt`, `write_data`, `reg_read`, `reg_write` and `reg_addrvalid`, and samples `read_data`.
- Converts a valid/ready command byte stream (from the host bridge / UART path) into multi-byte register reads and writes.
- Returns read bytes on a valid/ready response stream. Sits between the host link and any responder that decodes `reg_address[7:6]`.

---
 rtl/reg_cmd_master.sv | 121 ++++++++++++
 tb/tb_reg_cmd_master.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_cmd_master.sv
// reg_cmd_master: turns a valid/ready command byte stream into byte-wide register bus reads/writes; optional idle abort via REG_CMD_TIMEOUT_EN
module reg_cmd_master #(
  parameter int pBYTECNT_SIZE = 7,
  parameter int pTIMEOUT_CYCLES = 65535
) (
  input  logic                     usb_clk,
  input  logic                     reset_n,
  input  logic [7:0]               I_cmd_data,
  input  logic                     I_cmd_valid,
  output logic                     O_cmd_ready,
  output logic [7:0]               O_rsp_data,
  output logic                     O_rsp_valid,
  input  logic                     I_rsp_ready,
  output logic [7:0]               reg_address,
  output logic [pBYTECNT_SIZE-1:0] reg_bytecnt,
  output logic [7:0]               write_data,
  input  logic [7:0]               read_data,
  output logic                     reg_read,
  output logic                     reg_write,
  output logic                     reg_addrvalid,
  output logic                     O_busy,
  output logic                     O_timeout
);
  typedef enum logic [2:0] {IDLE, GET_ADDR, GET_LEN, WR_WAIT, WR_STB, RD_REQ, RD_CAP, RD_OUT} state_t;
  state_t state, nxt;
  logic is_read;
  logic [7:0] remaining;
  logic cmd_fire, rsp_fire, last, abort;
  logic ready_nxt, read_nxt, write_nxt, valid_nxt, av_nxt, busy_nxt;
  assign cmd_fire = I_cmd_valid & O_cmd_ready;
  assign rsp_fire = O_rsp_valid & I_rsp_ready;
  assign last = remaining == 8'd1;
`ifdef REG_CMD_TIMEOUT_EN
  localparam int TW = $clog2(pTIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle_cnt;
  logic waiting;
  assign waiting = state inside {GET_ADDR, GET_LEN, WR_WAIT, RD_OUT};
  assign abort = waiting & ~cmd_fire & ~rsp_fire & (idle_cnt == TW'(pTIMEOUT_CYCLES - 1));
  // count stalled cycles in the waiting states; any transfer restarts the count
  always_ff @(posedge usb_clk or negedge reset_n)
    if (!reset_n) begin
      idle_cnt <= '0;
      O_timeout <= 1'b0;
    end else begin
      idle_cnt <= (!waiting || cmd_fire || rsp_fire || abort) ? '0 : idle_cnt + TW'(1);
      O_timeout <= abort;
    end
`else
  logic unused_timeout;
  assign unused_timeout = pTIMEOUT_CYCLES == 0;
  assign abort = 1'b0;
  assign O_timeout = 1'b0;
`endif
  // state register plus all control outputs, registered from the next-state decode
  always_ff @(posedge usb_clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      O_cmd_ready <= 1'b0;
      reg_read <= 1'b0;
      reg_write <= 1'b0;
      O_rsp_valid <= 1'b0;
      reg_addrvalid <= 1'b0;
      O_busy <= 1'b0;
    end else begin
      state <= nxt;
      O_cmd_ready <= ready_nxt;
      reg_read <= read_nxt;
      reg_write <= write_nxt;
      O_rsp_valid <= valid_nxt;
      reg_addrvalid <= av_nxt;
      O_busy <= busy_nxt;
    end
  // next-state: header bytes, then per-byte write or two-cycle read with response handshake
  always_comb begin
    nxt = state;
    case (state)
      IDLE:     if (cmd_fire) nxt = GET_ADDR;
      GET_ADDR: if (cmd_fire) nxt = GET_LEN;
      GET_LEN:  if (cmd_fire) nxt = (I_cmd_data == 8'd0) ? IDLE : (is_read ? RD_REQ : WR_WAIT);
      WR_WAIT:  if (cmd_fire) nxt = WR_STB;
      WR_STB:   nxt = last ? IDLE : WR_WAIT;
      RD_REQ:   nxt = RD_CAP;
      RD_CAP:   nxt = RD_OUT;
      RD_OUT:   if (rsp_fire) nxt = last ? IDLE : RD_REQ;
      default:  nxt = IDLE;
    endcase
    if (abort) nxt = IDLE;
  end
  // output decode from the next state so every output is a plain flop
  always_comb begin
    ready_nxt = nxt inside {IDLE, GET_ADDR, GET_LEN, WR_WAIT};
    read_nxt = nxt inside {RD_REQ, RD_CAP};
    write_nxt = nxt == WR_STB;
    valid_nxt = nxt == RD_OUT;
    av_nxt = nxt inside {WR_WAIT, WR_STB, RD_REQ, RD_CAP, RD_OUT};
    busy_nxt = nxt != IDLE;
  end
  // header latches, write byte, read capture and per-byte counters
  always_ff @(posedge usb_clk or negedge reset_n)
    if (!reset_n) begin
      is_read <= 1'b0;
      reg_address <= '0;
      remaining <= '0;
      reg_bytecnt <= '0;
      write_data <= '0;
      O_rsp_data <= '0;
    end else begin
      if (state == IDLE && cmd_fire) is_read <= I_cmd_data[0];
      if (state == GET_ADDR && cmd_fire) reg_address <= I_cmd_data;
      if (state == GET_LEN && cmd_fire) begin
        remaining <= I_cmd_data;
        reg_bytecnt <= '0;
      end
      if (state == WR_WAIT && cmd_fire) write_data <= I_cmd_data;
      if (state == RD_CAP) O_rsp_data <= read_data;
      if (state == WR_STB || (state == RD_OUT && rsp_fire)) begin
        reg_bytecnt <= reg_bytecnt + pBYTECNT_SIZE'(1);
        remaining <= remaining - 8'd1;
      end
    end
endmodule

// File: tb/tb_reg_cmd_master.sv
// tb_reg_cmd_master: directed scoreboard bench for reg_cmd_master (timeout checks follow REG_CMD_TIMEOUT_EN)
module tb_reg_cmd_master;
  logic usb_clk = 1'b0;
  logic reset_n = 1'b1;
  logic [7:0] I_cmd_data = 8'h00;
  logic I_cmd_valid = 1'b0;
  logic O_cmd_ready;
  logic [7:0] O_rsp_data;
  logic O_rsp_valid;
  logic I_rsp_ready = 1'b1;
  logic [7:0] reg_address;
  logic [6:0] reg_bytecnt;
  logic [7:0] write_data;
  logic [7:0] read_data;
  logic reg_read, reg_write, reg_addrvalid, O_busy, O_timeout;
  int vectors = 0;
  int errors = 0;
  int rd_cycles = 0;
  int wr_cycles = 0;
  int n, first, rd0, w0;
  logic [23:0] wq[$];
  logic [7:0] rq[$];
  logic [7:0] exp_addr = 8'h00;
  logic [23:0] e;
  logic [7:0] r;

  reg_cmd_master #(.pBYTECNT_SIZE(7), .pTIMEOUT_CYCLES(16)) dut (
    .usb_clk(usb_clk), .reset_n(reset_n),
    .I_cmd_data(I_cmd_data), .I_cmd_valid(I_cmd_valid), .O_cmd_ready(O_cmd_ready),
    .O_rsp_data(O_rsp_data), .O_rsp_valid(O_rsp_valid), .I_rsp_ready(I_rsp_ready),
    .reg_address(reg_address), .reg_bytecnt(reg_bytecnt), .write_data(write_data),
    .read_data(read_data), .reg_read(reg_read), .reg_write(reg_write),
    .reg_addrvalid(reg_addrvalid), .O_busy(O_busy), .O_timeout(O_timeout)
  );

  assign read_data = 8'h10 + 8'(reg_bytecnt);

  always #5 usb_clk = ~usb_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge usb_clk);
    #2;
  endtask

  task automatic send(input logic [7:0] b);
    int k = 0;
    I_cmd_data = b;
    I_cmd_valid = 1'b1;
    while (!O_cmd_ready && k < 100) begin
      tick();
      k++;
    end
    chk("ready_wait", 32'(O_cmd_ready), 1);
    tick();
    I_cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (O_busy && k < 400) begin
      tick();
      k++;
    end
    chk("idle_wait", 32'(O_busy), 0);
  endtask

  // bus monitor: strobe exclusivity, write beats and response bytes against the scoreboard
  always @(negedge usb_clk) if (reset_n) begin
    chk("rw_excl", 32'(reg_read & reg_write), 0);
    if (reg_write) begin
      wr_cycles++;
      chk("wr_av", 32'(reg_addrvalid), 1);
      e = 'x;
      if (wq.size() != 0) e = wq.pop_front();
      chk("wr_beat", 32'({reg_address, 8'(reg_bytecnt), write_data}), 32'(e));
    end
    if (reg_read) begin
      rd_cycles++;
      chk("rd_addr", 32'(reg_address), 32'(exp_addr));
      chk("rd_av", 32'(reg_addrvalid), 1);
    end
    if (O_rsp_valid && I_rsp_ready) begin
      r = 'x;
      if (rq.size() != 0) r = rq.pop_front();
      chk("rsp_data", 32'(O_rsp_data), 32'(r));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 reset_n = 1'b0;
    #1;
    chk("reset_outs", 32'({O_cmd_ready, O_rsp_valid, reg_read, reg_write, reg_addrvalid, O_busy, O_timeout}), 0);
    chk("reset_regs", 32'({reg_address, 8'(reg_bytecnt), write_data, O_rsp_data}), 0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    chk("ready_after_reset", 32'(O_cmd_ready), 1);
    // two-byte write
    wq.push_back({8'h05, 8'h00, 8'hAA});
    wq.push_back({8'h05, 8'h01, 8'hBB});
    send(8'h00);
    send(8'h05);
    send(8'h02);
    chk("wr_av_after_len", 32'(reg_addrvalid), 1);
    send(8'hAA);
    chk("wr_stb_after_data", 32'(reg_write), 1);
    send(8'hBB);
    wait_idle();
    chk("wr_queue_empty", wq.size(), 0);
    chk("wr_pulses", wr_cycles, 2);
    chk("wr_av_end", 32'(reg_addrvalid), 0);
    // three-byte read, responder returns 0x10 + bytecnt
    exp_addr = 8'h41;
    rd0 = rd_cycles;
    rq.push_back(8'h10);
    rq.push_back(8'h11);
    rq.push_back(8'h12);
    send(8'h01);
    send(8'h41);
    send(8'h03);
    wait_idle();
    chk("rd_strobe_cycles", rd_cycles - rd0, 6);
    chk("rd_queue_empty", rq.size(), 0);
    // response backpressure
    I_rsp_ready = 1'b0;
    exp_addr = 8'h42;
    rd0 = rd_cycles;
    rq.push_back(8'h10);
    rq.push_back(8'h11);
    send(8'h01);
    send(8'h42);
    send(8'h02);
    n = 0;
    while (!O_rsp_valid && n < 50) begin
      tick();
      n++;
    end
    chk("bp_valid_seen", 32'(O_rsp_valid), 1);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("bp_hold", 32'({O_rsp_valid, O_rsp_data}), 'h110);
    end
    chk("bp_no_second_read", rd_cycles - rd0, 2);
    I_rsp_ready = 1'b1;
    wait_idle();
    chk("bp_total_reads", rd_cycles - rd0, 4);
    chk("bp_queue_empty", rq.size(), 0);
    // zero-length command
    rd0 = rd_cycles;
    w0 = wr_cycles;
    send(8'h00);
    send(8'h07);
    send(8'h00);
    chk("len0_busy", 32'(O_busy), 0);
    chk("len0_av", 32'(reg_addrvalid), 0);
    tick();
    tick();
    chk("len0_strobes", (rd_cycles - rd0) + (wr_cycles - w0), 0);
    // 130-byte write, bytecnt wraps after 127
    send(8'h00);
    send(8'h09);
    send(8'd130);
    for (int i = 0; i < 130; i++) begin
      wq.push_back({8'h09, 8'(i % 128), 8'(i ^ 'h5A)});
      send(8'(i ^ 'h5A));
    end
    wait_idle();
    chk("wrap_queue_empty", wq.size(), 0);
    chk("wrap_bytecnt_end", 32'(reg_bytecnt), 2);
    // asynchronous reset during a write strobe
    w0 = wr_cycles;
    send(8'h00);
    send(8'h05);
    send(8'h02);
    send(8'hEE);
    chk("rst_pre_stb", 32'({reg_write, reg_addrvalid}), 'h3);
    #1 reset_n = 1'b0;
    #1;
    chk("rst_async", 32'({reg_write, reg_addrvalid, O_busy, O_cmd_ready}), 0);
    tick();
    reset_n = 1'b1;
    wq.push_back({8'h05, 8'h00, 8'hCC});
    send(8'h00);
    send(8'h05);
    send(8'h01);
    send(8'hCC);
    wait_idle();
    chk("rst_after_queue_empty", wq.size(), 0);
    chk("rst_after_pulses", wr_cycles - w0, 1);
`ifdef REG_CMD_TIMEOUT_EN
    send(8'h00);
    send(8'h05);
    n = 0;
    first = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (O_timeout) begin
        n++;
        if (first == 0) first = k;
      end
    end
    chk("tmo_pulses", n, 1);
    chk("tmo_at_cycle", first, 16);
    chk("tmo_busy", 32'(O_busy), 0);
    wq.push_back({8'h05, 8'h00, 8'hDD});
    send(8'h00);
    send(8'h05);
    send(8'h01);
    send(8'hDD);
    wait_idle();
    chk("tmo_after_queue_empty", wq.size(), 0);
`else
    send(8'h00);
    send(8'h05);
    n = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (O_timeout) n++;
    end
    chk("no_tmo_pulses", n, 0);
    chk("no_tmo_still_busy", 32'({O_busy, O_cmd_ready}), 'h3);
    send(8'h00);
    wait_idle();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
